// File: rtl/hw_input_ctrl.sv
// Board-input front end: synchronizes and debounces KEY/SW pins, drives the CPU
// run/halt/single-step clock enable and a valid/ready switch-capture port.
module hw_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int SW_W            = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      key_n,
    input  logic [SW_W-1:0] sw,
    output logic [3:0]      key_level,
    output logic [3:0]      key_press,
    output logic            cpu_clk_en,
    output logic            running,
    output logic [SW_W-1:0] sw_data,
    output logic            sw_valid,
    input  logic            sw_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    // Two-flop synchronizers; keys idle high (released) out of reset.
    logic [3:0]      key_sync1_reg;
    logic [3:0]      key_sync2_reg;
    logic [SW_W-1:0] sw_sync1_reg;
    logic [SW_W-1:0] sw_sync2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_sync1_reg <= 4'hF;
            key_sync2_reg <= 4'hF;
            sw_sync1_reg  <= '0;
            sw_sync2_reg  <= '0;
        end else begin
            key_sync1_reg <= key_n;
            key_sync2_reg <= key_sync1_reg;
            sw_sync1_reg  <= sw;
            sw_sync2_reg  <= sw_sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic             pressed;
            logic             differ;
            logic             accept;
            logic [CNT_W-1:0] cnt_reg;
            logic             level_reg;
            logic             press_reg;

            assign pressed = ~key_sync2_reg[gi];
            assign differ  = pressed != level_reg;
            assign accept  = differ && (cnt_reg == CNT_LAST);

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                end else begin
                    // Pulse lands in the same cycle the level first reads 1.
                    press_reg <= accept && !level_reg;
                    if (!differ) begin
                        cnt_reg <= '0;
                    end else if (accept) begin
                        cnt_reg   <= '0;
                        level_reg <= ~level_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign key_level[gi] = level_reg;
            assign key_press[gi] = press_reg;
        end
    endgenerate

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= HALT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HALT: begin
                if (key_press[1]) begin
                    state_next = RUN;
                end else if (key_press[2]) begin
                    state_next = STEP;
                end
            end
            RUN: begin
                if (key_press[1]) begin
                    state_next = HALT;
                end
            end
            STEP:    state_next = HALT;
            default: state_next = HALT;
        endcase
    end

    always_comb begin
        cpu_clk_en = (state_reg == RUN) || (state_reg == STEP);
        running    = (state_reg == RUN);
    end

    logic [SW_W-1:0] sw_data_reg;
    logic            sw_valid_reg;

    // A new capture takes priority over a handshake completing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_data_reg  <= '0;
            sw_valid_reg <= 1'b0;
        end else if (key_press[3]) begin
            sw_data_reg  <= sw_sync2_reg;
            sw_valid_reg <= 1'b1;
        end else if (sw_valid_reg && sw_ready) begin
            sw_valid_reg <= 1'b0;
        end
    end

    assign sw_data  = sw_data_reg;
    assign sw_valid = sw_valid_reg;

endmodule

// File: tb/tb_hw_input_ctrl.sv
// Directed bench for hw_input_ctrl with a 4-cycle debounce window.
module tb_hw_input_ctrl;

    localparam int SW_W = 18;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      key_n;
    logic [SW_W-1:0] sw;
    logic [3:0]      key_level;
    logic [3:0]      key_press;
    logic            cpu_clk_en;
    logic            running;
    logic [SW_W-1:0] sw_data;
    logic            sw_valid;
    logic            sw_ready;

    int tests    = 0;
    int failures = 0;
    int press_cnt [4];
    int en_cnt     = 0;
    int en_low_cnt = 0;
    int snap_p;
    int snap_e;

    hw_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .SW_W           (SW_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .sw        (sw),
        .key_level (key_level),
        .key_press (key_press),
        .cpu_clk_en(cpu_clk_en),
        .running   (running),
        .sw_data   (sw_data),
        .sw_valid  (sw_valid),
        .sw_ready  (sw_ready)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) press_cnt[i] = 0;
    end

    // Pulse and enable bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) press_cnt[i] = press_cnt[i] + int'(key_press[i]);
            if (cpu_clk_en) en_cnt = en_cnt + 1;
            else            en_low_cnt = en_low_cnt + 1;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Hold a key long enough to be accepted, then release it fully.
    task automatic tap(input int k);
        key_n[k] = 1'b0;
        tick(8);
        key_n[k] = 1'b1;
        tick(8);
    endtask

    initial begin
        rst      = 1'b1;
        key_n    = 4'hF;
        sw       = '0;
        sw_ready = 1'b0;
        tick(2);
        check("rst_key_level", key_level, 4'h0);
        check("rst_key_press", key_press, 4'h0);
        check("rst_cpu_clk_en", cpu_clk_en, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_sw_valid", sw_valid, 1'b0);
        check("rst_sw_data", sw_data, 18'h0);
        rst = 1'b0;
        tick(2);

        // Clean KEY1 press: pulse in the 6th cycle counting the sampling cycle as 1.
        key_n[1] = 1'b0;
        tick(5);
        check("press1_early", key_press, 4'h0);
        check("level1_early", key_level, 4'h0);
        tick(1);
        check("press1_pulse", key_press, 4'b0010);
        check("level1_set", key_level, 4'b0010);
        check("run_not_yet", running, 1'b0);
        tick(1);
        check("press1_single", key_press, 4'h0);
        check("run_after_press", running, 1'b1);
        check("en_after_press", cpu_clk_en, 1'b1);
        tick(2);
        key_n[1] = 1'b1;
        tick(5);
        check("release1_early", key_level, 4'b0010);
        tick(1);
        check("release1_level", key_level, 4'h0);
        check("release1_nopulse", key_press, 4'h0);
        tick(2);
        check("run_held", running, 1'b1);
        tap(1);
        check("halt_running", running, 1'b0);
        check("halt_en", cpu_clk_en, 1'b0);

        // Bounce rejection on KEY2, then a solid press gives one step.
        snap_p = press_cnt[2];
        snap_e = en_cnt;
        for (int r = 0; r < 5; r++) begin
            key_n[2] = 1'b0;
            tick(3);
            key_n[2] = 1'b1;
            tick(1);
        end
        tick(2);
        check("bounce_level", key_level, 4'h0);
        check("bounce_presses", press_cnt[2], snap_p);
        key_n[2] = 1'b0;
        tick(10);
        check("solid_presses", press_cnt[2], snap_p + 1);
        check("solid_step_en", en_cnt, snap_e + 1);
        check("solid_back_halt", cpu_clk_en, 1'b0);
        tick(100);
        check("hold_presses", press_cnt[2], snap_p + 1);
        check("hold_steps", en_cnt, snap_e + 1);
        key_n[2] = 1'b1;
        tick(8);

        // Cycle-exact single step.
        key_n[2] = 1'b0;
        tick(6);
        check("step_pulse", key_press, 4'b0100);
        check("step_en_before", cpu_clk_en, 1'b0);
        tick(1);
        check("step_en_on", cpu_clk_en, 1'b1);
        check("step_not_running", running, 1'b0);
        tick(1);
        check("step_en_off", cpu_clk_en, 1'b0);
        key_n[2] = 1'b1;
        tick(8);

        // KEY2 in RUN is ignored; enable never drops.
        tap(1);
        check("run2_running", running, 1'b1);
        snap_e = en_low_cnt;
        snap_p = press_cnt[2];
        tap(2);
        check("run2_en_low", en_low_cnt, snap_e);
        check("run2_press_seen", press_cnt[2], snap_p + 1);
        check("run2_still_run", running, 1'b1);
        tap(1);
        check("run2_halt", running, 1'b0);

        // KEY1 and KEY2 land together: RUN wins.
        key_n = 4'b1001;
        tick(6);
        check("both_pulse", key_press, 4'b0110);
        tick(1);
        check("both_running", running, 1'b1);
        check("both_en", cpu_clk_en, 1'b1);
        tick(1);
        check("both_no_step", running, 1'b1);
        key_n = 4'hF;
        tick(8);
        tap(1);
        check("both_halt", running, 1'b0);

        // Switch capture handshake.
        sw = 18'h2A5A5;
        key_n[3] = 1'b0;
        tick(6);
        check("cap1_pulse", key_press, 4'b1000);
        check("cap1_valid_before", sw_valid, 1'b0);
        tick(1);
        check("cap1_data", sw_data, 18'h2A5A5);
        check("cap1_valid", sw_valid, 1'b1);
        tick(5);
        key_n[3] = 1'b1;
        tick(8);
        check("cap1_held_data", sw_data, 18'h2A5A5);
        check("cap1_held_valid", sw_valid, 1'b1);
        sw = 18'h00011;
        tap(3);
        check("cap2_data", sw_data, 18'h00011);
        check("cap2_valid", sw_valid, 1'b1);
        sw = 18'h15555;
        key_n[3] = 1'b0;
        tick(6);
        sw_ready = 1'b1;
        tick(1);
        sw_ready = 1'b0;
        check("cap3_coinc_data", sw_data, 18'h15555);
        check("cap3_coinc_valid", sw_valid, 1'b1);
        key_n[3] = 1'b1;
        tick(8);
        sw_ready = 1'b1;
        tick(1);
        sw_ready = 1'b0;
        check("ready_clears", sw_valid, 1'b0);
        check("ready_keeps_data", sw_data, 18'h15555);
        sw_ready = 1'b1;
        tick(1);
        sw_ready = 1'b0;
        tick(1);
        check("idle_ready_valid", sw_valid, 1'b0);
        check("idle_ready_data", sw_data, 18'h15555);

        // Reset with RUN, valid data and KEY0 mid-debounce.
        tap(1);
        sw = 18'h0ABCD;
        tap(3);
        check("pre_rst_running", running, 1'b1);
        check("pre_rst_valid", sw_valid, 1'b1);
        key_n[0] = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        check("mid_rst_en", cpu_clk_en, 1'b0);
        check("mid_rst_running", running, 1'b0);
        check("mid_rst_valid", sw_valid, 1'b0);
        check("mid_rst_data", sw_data, 18'h0);
        check("mid_rst_level", key_level, 4'h0);
        rst = 1'b0;
        tick(5);
        check("post_rst_level_early", key_level, 4'h0);
        tick(1);
        check("post_rst_level", key_level, 4'b0001);
        check("post_rst_press", key_press, 4'b0001);
        key_n[0] = 1'b1;
        tick(8);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/hw_input_ctrl.md
# hw_input_ctrl

Board-input front end for the DE2-115 CPU wrapper: the counterpart to the LED/HEX output path. It synchronizes and debounces the four active-low push buttons and the 18 slide switches. It turns button presses into a run/halt/single-step clock-enable for the CPU core, and hands switch values to the CPU through a valid/ready handshake. It sits between the top-level KEY/SW pins and the CPU's clock-enable and input-port logic.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); minimum 2.
- CNT_W, 20: debounce counter width; must hold DEBOUNCE_CYCLES-1.
- SW_W, 18: switch bus width.

- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  reset, synchronous, active-high.
- key_n  in  4  raw push buttons, active-low, asynchronous.
- sw  in  SW_W  raw slide switches, asynchronous.
- key_level  out  4  debounced key state, 1 = pressed.
- key_press  out  4  one-cycle pulse per accepted press.
- cpu_clk_en  out  1  CPU clock enable.
- running  out  1  1 while the controller is in RUN.
- sw_data  out  SW_W  captured switch value.
- sw_valid  out  1  sw_data available to the CPU.
- sw_ready  in  1  CPU accepts sw_data.

## Operation
- Sync: key_n and sw each pass through a 2-flop synchronizer. The key synchronizers reset to 1 (released). The switch synchronizers reset to 0.
- Debounce, per key, independent:
  - Compare the synced pressed level (~key_n) with key_level.
  - If they differ, increment the counter. If they are equal, clear it.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, toggle key_level and clear the counter.
  - Any bounce shorter than DEBOUNCE_CYCLES consecutive cycles produces no change.
- key_press[i] is registered. It is high for exactly the cycle in which key_level[i] first reads 1. Releases produce no pulse.
- Key roles: KEY1 = run/halt toggle, KEY2 = single step, KEY3 = capture switches. KEY0 is reported on key_level/key_press only.
- Run FSM, states HALT (reset), RUN, STEP:
  - HALT: key_press[1] -> RUN. Otherwise key_press[2] -> STEP. If both are pressed in the same cycle, RUN wins.
  - RUN: key_press[1] -> HALT. key_press[2] is ignored.
  - STEP: unconditionally -> HALT after one cycle. Key presses during STEP are ignored.
  - cpu_clk_en = (state==RUN)|(state==STEP), decoded from the state register.
  - running = (state==RUN).
- Switch handshake:
  - key_press[3] loads sw_data from the synced sw and sets sw_valid.
  - sw_valid&&sw_ready in a cycle clears sw_valid on the next edge.
  - sw_data holds its value until the next capture.
  - A capture while valid and not ready overwrites sw_data; sw_valid stays 1.
  - A capture in the same cycle as a completed handshake loads the new data and sw_valid stays 1 (new transfer wins).
  - sw_ready while sw_valid=0 has no effect.

## Timing
- Reset values:
  - key_level=0, key_press=0, debounce counters=0.
  - FSM=HALT, so cpu_clk_en=0 and running=0.
  - sw_data=0, sw_valid=0.
- Press latency:
  - A raw key_n fall held stable reaches key_level/key_press DEBOUNCE_CYCLES+2 cycles after the first clock edge that samples it low.
  - Release follows the same latency.
- FSM latency:
  - key_press in cycle N gives a new state, and new cpu_clk_en/running, in cycle N+1.
  - A step gives cpu_clk_en=1 for exactly cycle N+1 and 0 from N+2.
- Capture latency: key_press[3] in cycle N gives sw_data/sw_valid updated in N+1.
- rst mid-operation: all state returns to reset values on the next edge, including a pending sw_valid and a partial debounce count.

## Test plan
Run with DEBOUNCE_CYCLES=4.
- Clean press: after reset, drive key_n=4'b1111, then key_n[1]=0 held.
  - key_press[1] pulses once, 6 cycles after the first low sample.
  - running=1 and cpu_clk_en=1 one cycle later.
  - A second KEY1 press returns running=0 and cpu_clk_en=0.
- Bounce rejection: toggle key_n[2] low for 3 cycles, high for 1, repeated 5 times.
  - key_level[2] stays 0 and no key_press.
  - Then hold low for 10 cycles: exactly one key_press[2].
- Single step: in HALT, press KEY2.
  - cpu_clk_en is high for exactly 1 cycle, then the FSM is back in HALT.
  - Holding KEY2 for 100 cycles still gives only one step.
  - Pressing KEY2 while in RUN leaves cpu_clk_en continuously 1.
- Simultaneous: force key_press[1] and key_press[2] in the same cycle from HALT (both keys fall on the same edge) -> state RUN, no STEP cycle observed.
- Switch handshake:
  - sw=18'h2A5A5, press KEY3 with sw_ready=0 -> sw_data=18'h2A5A5, sw_valid=1, held.
  - Change sw to 18'h00011 and press KEY3 again -> sw_data=18'h00011, sw_valid=1.
  - Pulse sw_ready for 1 cycle -> sw_valid=0 on the next cycle.
  - Capture coincident with sw_ready -> sw_valid stays 1 with the new data.
- Reset mid-operation: in RUN with sw_valid=1 and a key mid-debounce, assert rst for 1 cycle.
  - Next cycle: cpu_clk_en=0, running=0, sw_valid=0, sw_data=0, key_level=0.
  - The interrupted key requires a full DEBOUNCE_CYCLES again.
